js_button_conditioner: RTL

JS_BUTTON_CONDITIONER -- requirements
Module: js_button_conditioner

---
 rtl/js_button_conditioner_pkg.sv | 19 +
 rtl/js_button_conditioner_cell.sv | 54 +++++
 rtl/js_button_conditioner.sv | 41 ++++
 3 files changed

// File: rtl/js_button_conditioner_pkg.sv
// Joystick button conditioner shared definitions.
// Button indices, button count, default debounce length and counter sizing.
package js_button_conditioner_pkg;

    localparam int unsigned BTN_A    = 0;
    localparam int unsigned BTN_B    = 1;
    localparam int unsigned BTN_C    = 2;
    localparam int unsigned BTN_D    = 3;
    localparam int unsigned BTN_F    = 4;
    localparam int unsigned NUM_BTNS = 5;

    // 10 ms at 25 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/js_button_conditioner_cell.sv
// js_debounce_cell: 2-flop synchronizer, mismatch counter, stable level, press pulse.
// Ports: vga_clk, arst_n, raw_n (async, active-low), level (stable, active-low), pulse.
module js_debounce_cell
    import js_button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic vga_clk,
    input  logic arst_n,
    input  logic raw_n,
    output logic level,
    output logic pulse
);

    localparam int unsigned     CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Synchronizer idles at the released level.
    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
        end
    end

    // Any cycle agreeing with the stable level restarts the count.
    // A commit to 0 is a press and raises the pulse in the same cycle.
    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
            level <= 1'b1;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                cnt   <= '0;
                pulse <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/js_button_conditioner.sv
// Joystick button conditioner top: one debounce cell per button.
// Ports: vga_clk, arst_n, btn_raw_n[4:0] {f,d,c,b,a}, debounced levels, press pulses.
module js_button_conditioner
    import js_button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                vga_clk,
    input  logic                arst_n,
    input  logic [NUM_BTNS-1:0] btn_raw_n,
    output logic                js_button_a,
    output logic                js_button_b,
    output logic                js_button_c,
    output logic                js_button_d,
    output logic                js_button_f,
    output logic                js_button_f_d,
    output logic [NUM_BTNS-1:0] press_pulse
);

    logic [NUM_BTNS-1:0] level;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_cell
        js_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .vga_clk(vga_clk),
            .arst_n (arst_n),
            .raw_n  (btn_raw_n[i]),
            .level  (level[i]),
            .pulse  (press_pulse[i])
        );
    end

    assign js_button_a   = level[BTN_A];
    assign js_button_b   = level[BTN_B];
    assign js_button_c   = level[BTN_C];
    assign js_button_d   = level[BTN_D];
    assign js_button_f   = level[BTN_F];
    assign js_button_f_d = press_pulse[BTN_F];

endmodule
